snake_game_ctrl: RTL and testbench
==================================

Name: snake_game_ctrl

Overview:
Game-step controller sitting directly upstream of the snake body engine.
- Paces the game with a tick divider and latches the player's direction.
- Issues the one-cycle shift request, waits for end_shift, then judges the new head against food and self-collision.
- Drives snake reset, move, length, score and game-over to the rest of the design.

Parameters:
H, 32, grid width in cells (power of 2; head coordinates wrap).
V, 32, grid height in cells (power of 2).
TICK_DIV, 3000000, clk cycles spent in WAIT_TICK per game step (>=2).
INIT_LEN, 3, snake length after start (1..H*V-1).
SETTLE, 2, cycles waited after end_shift before last_head/self_col are sampled.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
start  in  1  level; rising edge starts a game from IDLE or GAME_OVER
btn_dir  in  4  debounced levels {down,left,up,right} = bits [3:0]
end_shift  in  1  one-cycle pulse from snake engine: body walk finished
self_col  in  1  sticky self-collision flag from snake engine
last_head  in  logb2(H)+logb2(V)+1  {x,y,active} of head from snake engine
food_x  in  logb2(H)  current food cell x
food_y  in  logb2(V)  current food cell y
snake_rst  out  1  synchronous active-high reset to snake engine
move  out  2  committed direction: 0 right, 1 up, 2 left, 3 down
length  out  logb2(H*V)  current snake length
shift  out  1  one-cycle step request to snake engine
food_eat  out  1  one-cycle pulse: head hit food (food generator relocates)
score  out  16  foods eaten, saturating at 16'hFFFF
game_over  out  1  high in GAME_OVER
watchdog_err  out  1  sticky: end_shift never arrived; cleared on start

Behaviour:
- Reset (async, reset=0), all outputs: state IDLE, snake_rst=1, move=0, length=INIT_LEN, shift=0, food_eat=0, score=0, game_over=0, watchdog_err=0, pending dir=right.
- Reset deasserts into IDLE. Reset may arrive in any state; the FSM returns to IDLE immediately.
- start edge detect: one internal flop holds the last start value; start_rise = start & ~start_q.
- States:
  - IDLE: snake_rst=1. On start_rise -> INIT.
  - INIT: one cycle. snake_rst=1, length=INIT_LEN, score=0, move=right, pending=right, watchdog_err=0, game_over=0 -> WAIT_TICK.
  - WAIT_TICK: snake_rst=0. Tick counter runs from 0. On count==TICK_DIV-1: move<=pending, shift=1 for exactly this one transition cycle -> BUSY.
  - BUSY: watchdog counts cycles.
    - end_shift seen -> SETTLE.
    - Count reaches H*V+8 -> watchdog_err=1 -> GAME_OVER.
  - SETTLE: count SETTLE cycles -> CHECK.
  - CHECK (one cycle):
    - self_col=1 -> GAME_OVER.
    - Else if last_head[x]==food_x and last_head[y]==food_y: food_eat=1, score+1 (saturating), length+1 (saturating at H*V-1, takes effect next step) -> WAIT_TICK.
    - Else -> WAIT_TICK.
  - GAME_OVER: game_over=1. Outputs other than snake_rst hold. On start_rise -> INIT.
- Step period = TICK_DIV + 1 + engine walk time + SETTLE + 1 cycles. The tick counter is cleared on every WAIT_TICK entry.
- Direction latch, sampled every cycle in WAIT_TICK/BUSY/SETTLE/CHECK:
  - Priority right>up>left>down when several btn_dir bits are set; btn_dir=0 leaves pending unchanged.
  - A request opposite to the committed move (XOR 2'b10) is ignored.
  - move changes only at the shift cycle, so it is stable throughout an engine walk.
- No wall collision: coordinates wrap mod H/V in the engine.
- shift and food_eat never assert outside the cycles above. shift and end_shift never overlap.

Decomposition:
- snake_pkg (shared header): direction localparams RIGHT/UP/LEFT/DOWN, FSM state encodings, logb2 function. The snake engine and the renderer use the same definitions.
- Sub-module: reuse the existing StaticCounter as the tick divider (StaticCounter #(TICK_DIV-1)). The watchdog and SETTLE counters stay inline.

Test Plan:
- Reset low mid-BUSY with TICK_DIV=4 -> next cycle state IDLE, snake_rst=1, shift=0, length=3, score=0.
- Start pulse, TICK_DIV=4, end_shift returned 10 cycles after shift, no food hit -> shift pulses of width 1, adjacent pulses 4+1+10+2+1 cycles apart, move=0.
- Hold btn_dir=4'b0100 (left) while move=right -> move stays 0. Then btn_dir=4'b0010 (up) -> move=1 at the next shift cycle only.
- last_head={food_x,food_y,1} at CHECK, with length=3 and score=0 -> food_eat one cycle, score=1, length=4. With length=1023 -> length stays 1023.
- self_col=1 at CHECK -> game_over=1 and no further shift. Start rise -> INIT, game_over=0, length=3.
- Withhold end_shift after shift -> watchdog_err=1 and game_over=1 after H*V+8=1032 cycles.

Source files
------------

// File: rtl/snake_game_ctrl_pkg.sv
// Shared snake definitions: directions, controller states and sizing helpers.
package snake_game_ctrl_pkg;

  localparam logic [1:0] RIGHT = 2'd0;
  localparam logic [1:0] UP    = 2'd1;
  localparam logic [1:0] LEFT  = 2'd2;
  localparam logic [1:0] DOWN  = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_INIT      = 3'd1,
    ST_WAIT_TICK = 3'd2,
    ST_BUSY      = 3'd3,
    ST_SETTLE    = 3'd4,
    ST_CHECK     = 3'd5,
    ST_GAME_OVER = 3'd6
  } state_e;

  // Number of bits needed to index 'value' cells (ceil log2).
  function automatic int unsigned logb2(input int unsigned value);
    int unsigned bits;
    bits = 0;
    while ((64'd1 << bits) < 64'(value)) bits = bits + 1;
    return bits;
  endfunction

  // Button levels {down,left,up,right} to a direction, right having top priority.
  function automatic logic [1:0] btn_to_dir(input logic [3:0] btn);
    logic [1:0] dir;
    dir = RIGHT;
    if (btn[0])      dir = RIGHT;
    else if (btn[1]) dir = UP;
    else if (btn[2]) dir = LEFT;
    else if (btn[3]) dir = DOWN;
    return dir;
  endfunction

endpackage

// File: rtl/snake_game_ctrl_if.sv
// Step handshake and head/food data between the game controller and the body engine.
interface snake_game_ctrl_if
  import snake_game_ctrl_pkg::*;
#(
  parameter int unsigned H = 32,
  parameter int unsigned V = 32
) ();

  localparam int unsigned XW = logb2(H);
  localparam int unsigned YW = logb2(V);
  localparam int unsigned LW = logb2(H * V);

  logic              snake_rst;
  logic [1:0]        move;
  logic [LW-1:0]     length;
  logic              shift;
  logic              food_eat;
  logic              end_shift;
  logic              self_col;
  logic [XW+YW:0]    last_head;
  logic [XW-1:0]     food_x;
  logic [YW-1:0]     food_y;

  modport master (
    output snake_rst, move, length, shift, food_eat,
    input  end_shift, self_col, last_head, food_x, food_y
  );

  modport slave (
    input  snake_rst, move, length, shift, food_eat,
    output end_shift, self_col, last_head, food_x, food_y
  );

endinterface

// File: rtl/snake_game_ctrl_static_counter.sv
// Free-running modulo counter with clear; flags the terminal count MAX.
module snake_game_ctrl_static_counter #(
  parameter int unsigned MAX = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic done_c
);

  localparam int unsigned W = (MAX < 1) ? 1 : $clog2(MAX + 1);

  logic [W-1:0] cnt;

  // Count 0..MAX and wrap; clr has priority over en.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == W'(MAX)) ? '0 : cnt + W'(1);
    end
  end

  assign done_c = (cnt == W'(MAX));

endmodule

// File: rtl/snake_game_ctrl.sv
// Game-step controller: paces steps, latches direction, judges food and collisions.
module snake_game_ctrl
  import snake_game_ctrl_pkg::*;
#(
  parameter int unsigned H        = 32,
  parameter int unsigned V        = 32,
  parameter int unsigned TICK_DIV = 3000000,
  parameter int unsigned INIT_LEN = 3,
  parameter int unsigned SETTLE   = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [3:0]         btn_dir,
  snake_game_ctrl_if.master  eng,
  output logic [15:0]        score,
  output logic               game_over,
  output logic               watchdog_err
);

  localparam int unsigned XW      = logb2(H);
  localparam int unsigned YW      = logb2(V);
  localparam int unsigned LW      = logb2(H * V);
  localparam int unsigned LEN_MAX = H * V - 1;
  localparam int unsigned WD_LAST = H * V + 7;
  localparam int unsigned WD_W    = $clog2(H * V + 8);
  localparam int unsigned ST_LAST = (SETTLE < 1) ? 0 : SETTLE - 1;
  localparam int unsigned ST_W    = (SETTLE < 2) ? 1 : $clog2(SETTLE);

  state_e          state, state_d;
  logic            start_q;
  logic [1:0]      pending, pending_d;
  logic [1:0]      move_q, move_d;
  logic [LW-1:0]   length_q, length_d;
  logic            shift_q, shift_d;
  logic            food_eat_q, food_eat_d;
  logic            snake_rst_q, snake_rst_d;
  logic [15:0]     score_d;
  logic            game_over_d;
  logic            wd_err_d;
  logic [WD_W-1:0] wd_cnt, wd_cnt_d;
  logic [ST_W-1:0] st_cnt, st_cnt_d;

  logic            start_rise_c;
  logic            tick_done_c;
  logic [1:0]      dir_req_c;
  logic            head_hit_c;
  logic [XW-1:0]   head_x_c;
  logic [YW-1:0]   head_y_c;
  logic            unused_head_active;

  assign start_rise_c       = start & ~start_q;
  assign dir_req_c          = btn_to_dir(btn_dir);
  assign head_x_c           = eng.last_head[XW+YW -: XW];
  assign head_y_c           = eng.last_head[YW -: YW];
  assign head_hit_c         = (head_x_c == eng.food_x) && (head_y_c == eng.food_y);
  assign unused_head_active = eng.last_head[0];

  // Tick divider: cleared outside WAIT_TICK so every wait restarts from zero.
  snake_game_ctrl_static_counter #(
    .MAX (TICK_DIV - 1)
  ) u_tick (
    .clk    (clk),
    .reset  (reset),
    .clr    (state != ST_WAIT_TICK),
    .en     (state == ST_WAIT_TICK),
    .done_c (tick_done_c)
  );

  // Next state and next register values; outputs follow the state being entered.
  always_comb begin
    state_d    = state;
    pending_d  = pending;
    move_d     = move_q;
    length_d   = length_q;
    score_d    = score;
    wd_err_d   = watchdog_err;
    food_eat_d = 1'b0;
    wd_cnt_d   = '0;
    st_cnt_d   = '0;

    case (state)
      ST_IDLE: begin
        if (start_rise_c) state_d = ST_INIT;
      end
      ST_INIT: begin
        state_d = ST_WAIT_TICK;
      end
      ST_WAIT_TICK: begin
        if (tick_done_c) begin
          state_d = ST_BUSY;
          move_d  = pending;
        end
      end
      ST_BUSY: begin
        if (eng.end_shift) begin
          state_d = ST_SETTLE;
        end else if (wd_cnt == WD_W'(WD_LAST)) begin
          state_d  = ST_GAME_OVER;
          wd_err_d = 1'b1;
        end else begin
          wd_cnt_d = wd_cnt + WD_W'(1);
        end
      end
      ST_SETTLE: begin
        if (st_cnt == ST_W'(ST_LAST)) state_d = ST_CHECK;
        else                          st_cnt_d = st_cnt + ST_W'(1);
      end
      ST_CHECK: begin
        if (eng.self_col) begin
          state_d = ST_GAME_OVER;
        end else begin
          state_d = ST_WAIT_TICK;
          if (head_hit_c) begin
            food_eat_d = 1'b1;
            score_d    = (score == 16'hFFFF) ? score : score + 16'd1;
            length_d   = (length_q == LW'(LEN_MAX)) ? length_q : length_q + LW'(1);
          end
        end
      end
      ST_GAME_OVER: begin
        if (start_rise_c) state_d = ST_INIT;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A reversal onto the body is dropped; no button keeps the previous request.
    if ((state inside {ST_WAIT_TICK, ST_BUSY, ST_SETTLE, ST_CHECK}) &&
        (btn_dir != 4'd0) && (dir_req_c != (move_q ^ 2'b10))) begin
      pending_d = dir_req_c;
    end

    if (state_d == ST_INIT) begin
      length_d  = LW'(INIT_LEN);
      score_d   = 16'd0;
      move_d    = RIGHT;
      pending_d = RIGHT;
      wd_err_d  = 1'b0;
    end

    shift_d     = (state == ST_WAIT_TICK) && tick_done_c;
    snake_rst_d = (state_d == ST_IDLE) || (state_d == ST_INIT) || (state_d == ST_GAME_OVER);
    game_over_d = (state_d == ST_GAME_OVER);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= ST_IDLE;
      start_q      <= 1'b0;
      pending      <= RIGHT;
      move_q       <= RIGHT;
      length_q     <= LW'(INIT_LEN);
      shift_q      <= 1'b0;
      food_eat_q   <= 1'b0;
      snake_rst_q  <= 1'b1;
      score        <= 16'd0;
      game_over    <= 1'b0;
      watchdog_err <= 1'b0;
      wd_cnt       <= '0;
      st_cnt       <= '0;
    end else begin
      state        <= state_d;
      start_q      <= start;
      pending      <= pending_d;
      move_q       <= move_d;
      length_q     <= length_d;
      shift_q      <= shift_d;
      food_eat_q   <= food_eat_d;
      snake_rst_q  <= snake_rst_d;
      score        <= score_d;
      game_over    <= game_over_d;
      watchdog_err <= wd_err_d;
      wd_cnt       <= wd_cnt_d;
      st_cnt       <= st_cnt_d;
    end
  end

  assign eng.snake_rst = snake_rst_q;
  assign eng.move      = move_q;
  assign eng.length    = length_q;
  assign eng.shift     = shift_q;
  assign eng.food_eat  = food_eat_q;

endmodule

// File: tb/tb_snake_game_ctrl.sv
// Directed bench for snake_game_ctrl with a small body-engine responder.
module tb_snake_game_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  btn_dir = 4'd0;
  logic [15:0] score;
  logic        game_over;
  logic        watchdog_err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int resp_delay = 10;

  logic [10:0] head_hit;
  logic [10:0] head_miss_x;
  logic [10:0] head_miss_y;

  typedef struct {
    logic [3:0] btn;
    bit         hit;
    int         mv;
    int         eat;
    int         sc;
    int         len;
  } vec_t;

  vec_t vecs[10];

  snake_game_ctrl_if #(.H(32), .V(32)) eng ();

  snake_game_ctrl #(
    .H        (32),
    .V        (32),
    .TICK_DIV (4),
    .INIT_LEN (3),
    .SETTLE   (2)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .btn_dir      (btn_dir),
    .eng          (eng),
    .score        (score),
    .game_over    (game_over),
    .watchdog_err (watchdog_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Engine stand-in: returns end_shift resp_delay cycles after shift (0 = never).
  initial begin
    eng.end_shift = 1'b0;
    forever begin
      @(negedge clk);
      if (eng.shift && resp_delay > 0) begin
        repeat (resp_delay) @(negedge clk);
        eng.end_shift = 1'b1;
        @(negedge clk);
        eng.end_shift = 1'b0;
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Wait (bounded) for shift (sel 0), food_eat (sel 1) or game_over (sel 2).
  task automatic wait_for(input int sel, input int limit, input string name);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < limit && !seen; i++) begin
      @(negedge clk);
      case (sel)
        0:       seen = eng.shift;
        1:       seen = eng.food_eat;
        default: seen = game_over;
      endcase
    end
    chk(name, int'(seen), 1);
  endtask

  initial begin
    int s_now;
    int s_prev;
    int n_shift;
    int n_eat;

    head_hit    = {5'd7, 5'd19, 1'b1};
    head_miss_x = {5'd8, 5'd19, 1'b1};
    head_miss_y = {5'd7, 5'd20, 1'b1};

    vecs[0] = '{4'b0100, 1'b0, 0, 0, 0, 3};
    vecs[1] = '{4'b0010, 1'b1, 1, 1, 1, 4};
    vecs[2] = '{4'b1000, 1'b0, 1, 0, 1, 4};
    vecs[3] = '{4'b0100, 1'b1, 2, 1, 2, 5};
    vecs[4] = '{4'b0001, 1'b1, 2, 1, 3, 6};
    vecs[5] = '{4'b1001, 1'b0, 2, 0, 3, 6};
    vecs[6] = '{4'b1000, 1'b0, 3, 0, 3, 6};
    vecs[7] = '{4'b0110, 1'b1, 3, 1, 4, 7};
    vecs[8] = '{4'b0000, 1'b0, 3, 0, 4, 7};
    vecs[9] = '{4'b1111, 1'b0, 0, 0, 4, 7};

    eng.self_col  = 1'b0;
    eng.food_x    = 5'd7;
    eng.food_y    = 5'd19;
    eng.last_head = head_miss_y;
    s_prev = 0;

    // Reset values
    #2 reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_snake_rst", int'(eng.snake_rst), 1);
    chk("rst_move", int'(eng.move), 0);
    chk("rst_length", int'(eng.length), 3);
    chk("rst_shift", int'(eng.shift), 0);
    chk("rst_food_eat", int'(eng.food_eat), 0);
    chk("rst_score", int'(score), 0);
    chk("rst_game_over", int'(game_over), 0);
    chk("rst_watchdog", int'(watchdog_err), 0);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_snake_rst", int'(eng.snake_rst), 1);

    // Table-driven steps: direction latch, food judging and step period
    btn_dir       = vecs[0].btn;
    eng.last_head = head_miss_x;
    start         = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (i > 0) begin
        btn_dir       = vecs[i].btn;
        eng.last_head = vecs[i].hit ? head_hit : ((i % 2) == 1 ? head_miss_x : head_miss_y);
      end
      wait_for(0, 60, "shift_seen");
      s_now = cyc;
      if (i > 0) chk("step_period", s_now - s_prev, 18);
      s_prev = s_now;
      start = 1'b0;
      chk($sformatf("v%0d_move", i), int'(eng.move), vecs[i].mv);
      chk($sformatf("v%0d_snake_rst", i), int'(eng.snake_rst), 0);
      @(negedge clk);
      chk($sformatf("v%0d_shift_width", i), int'(eng.shift), 0);
      repeat (13) @(negedge clk);
      chk($sformatf("v%0d_food_eat", i), int'(eng.food_eat), vecs[i].eat);
      chk($sformatf("v%0d_score", i), int'(score), vecs[i].sc);
      chk($sformatf("v%0d_length", i), int'(eng.length), vecs[i].len);
      @(negedge clk);
      chk($sformatf("v%0d_food_eat_low", i), int'(eng.food_eat), 0);
    end

    // Reset asserted in the middle of an engine walk
    btn_dir = 4'd0;
    wait_for(0, 40, "shift_before_reset");
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("midrst_snake_rst", int'(eng.snake_rst), 1);
    chk("midrst_shift", int'(eng.shift), 0);
    chk("midrst_length", int'(eng.length), 3);
    chk("midrst_score", int'(score), 0);
    chk("midrst_move", int'(eng.move), 0);
    @(negedge clk);
    chk("midrst_next_snake_rst", int'(eng.snake_rst), 1);
    reset = 1'b1;
    n_shift = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (eng.shift) n_shift++;
    end
    chk("idle_no_shift", n_shift, 0);
    chk("idle_after_rst_snake_rst", int'(eng.snake_rst), 1);

    // Length saturation: eat on every step
    eng.last_head = head_hit;
    resp_delay    = 1;
    start         = 1'b1;
    for (int k = 1; k <= 1022; k++) begin
      wait_for(1, 40, "food_eat_seen");
      if (k == 1) start = 1'b0;
      if (k == 1019) chk("len_before_sat", int'(eng.length), 1022);
    end
    chk("len_saturated", int'(eng.length), 1023);
    chk("score_after_sat", int'(score), 1022);

    // Self collision ends the game and stops stepping
    eng.self_col = 1'b1;
    wait_for(2, 40, "game_over_seen");
    chk("selfcol_game_over", int'(game_over), 1);
    chk("selfcol_len_hold", int'(eng.length), 1023);
    chk("selfcol_score_hold", int'(score), 1022);
    eng.self_col = 1'b0;
    n_shift = 0;
    n_eat = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (eng.shift) n_shift++;
      if (eng.food_eat) n_eat++;
    end
    chk("gameover_no_shift", n_shift, 0);
    chk("gameover_no_eat", n_eat, 0);
    chk("gameover_held", int'(game_over), 1);

    // Restart from GAME_OVER
    resp_delay = 0;
    start = 1'b1;
    @(negedge clk);
    chk("init_game_over", int'(game_over), 0);
    chk("init_length", int'(eng.length), 3);
    chk("init_score", int'(score), 0);
    chk("init_snake_rst", int'(eng.snake_rst), 1);
    start = 1'b0;

    // Watchdog: end_shift withheld
    wait_for(0, 40, "shift_before_watchdog");
    repeat (1031) @(negedge clk);
    chk("wd_not_yet", int'(watchdog_err), 0);
    chk("wd_go_not_yet", int'(game_over), 0);
    @(negedge clk);
    chk("wd_err", int'(watchdog_err), 1);
    chk("wd_game_over", int'(game_over), 1);
    start = 1'b1;
    @(negedge clk);
    chk("wd_cleared_on_start", int'(watchdog_err), 0);
    start = 1'b0;
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
